// File: rtl/adder4_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : adder4_if
//  Description : Operand/result bundle for the excess-3 adder. The master
//                side drives the operands A and B and observes every
//                result. The slave side (the adder) consumes the operands and
//                drives the results.
//  Signals     : A, B         - 4-bit operands
//                sum_e3       - combinational (A + B + OFFSET) mod 16
//                overflow     - combinational sign-overflow flag
//                sum_q        - sum_e3 registered on clk
//                overflow_q   - overflow registered on clk
//                ovf_sticky   - sticky overflow (constant 0 unless enabled)
//  Revision    : 1.0 - initial release
// ============================================================================
interface adder4_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] sum_e3;
    logic       overflow;
    logic [3:0] sum_q;
    logic       overflow_q;
    logic       ovf_sticky;

    modport master (
        output A, B,
        input  sum_e3, overflow, sum_q, overflow_q, ovf_sticky
    );

    modport slave (
        input  A, B,
        output sum_e3, overflow, sum_q, overflow_q, ovf_sticky
    );
endinterface
`default_nettype wire

// File: rtl/adder4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : adder4
//  Description : 4-bit excess-3 adder. Computes (A + B + OFFSET) mod 16 with
//                a ripple-carry chain of full adders (A + B first, OFFSET
//                injected as a second addend stage), plus a sign-overflow
//                flag judged against the final excess-3 result. Combinational
//                results are also provided as registered copies.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous, active-high reset (registered outputs)
//                bus  - adder4_if.slave (A, B in; sum_e3, overflow, sum_q,
//                       overflow_q, ovf_sticky out)
//  Parameters  : OFFSET - constant addend, 0..15 (3 gives excess-3)
//  Config      : ADDER4_STICKY_OVF_EN - when defined, ovf_sticky is a flop
//                set by any clock edge seeing overflow and cleared only by
//                rst; when undefined, ovf_sticky is constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder4 #(
    parameter logic [3:0] OFFSET = 4'd3
) (
    input  wire logic  clk,
    input  wire logic  rst,
    adder4_if.slave    bus
);

    // Internal sum is kept wider than the result so no intermediate carry is
    // lost before the final truncation to 4 bits.
    localparam int c_SUM_W = 6;
    localparam int c_PAD_W = c_SUM_W - 4;

    logic [c_SUM_W-1:0] w_op_a;
    logic [c_SUM_W-1:0] w_op_b;
    logic [c_SUM_W-1:0] w_offset;
    logic [c_SUM_W-1:0] w_ab_sum;
    logic [c_SUM_W:0]   w_ab_carry;
    logic [c_SUM_W-1:0] w_full_sum;
    logic [c_SUM_W:0]   w_full_carry;
    logic [3:0]         w_sum_e3;
    logic               w_overflow;
    logic [3:0]         w_unused_bits;

    logic [3:0]         r_sum_q;
    logic               r_overflow_q;

    assign w_op_a   = {{c_PAD_W{1'b0}}, bus.A};
    assign w_op_b   = {{c_PAD_W{1'b0}}, bus.B};
    assign w_offset = {{c_PAD_W{1'b0}}, OFFSET};

    assign w_ab_carry[0]   = 1'b0;
    assign w_full_carry[0] = 1'b0;

    // Stage 1: A + B
    for (genvar gi = 0; gi < c_SUM_W; gi++) begin : g_ab_ripple
        assign w_ab_sum[gi]     = w_op_a[gi] ^ w_op_b[gi] ^ w_ab_carry[gi];
        assign w_ab_carry[gi+1] = (w_op_a[gi] & w_op_b[gi])
                                | (w_ab_carry[gi] & (w_op_a[gi] ^ w_op_b[gi]));
    end

    // Stage 2: (A + B) + OFFSET
    for (genvar gj = 0; gj < c_SUM_W; gj++) begin : g_offset_ripple
        assign w_full_sum[gj]     = w_ab_sum[gj] ^ w_offset[gj] ^ w_full_carry[gj];
        assign w_full_carry[gj+1] = (w_ab_sum[gj] & w_offset[gj])
                                  | (w_full_carry[gj] & (w_ab_sum[gj] ^ w_offset[gj]));
    end

    // Carries and bits above bit 3 are intentionally discarded (mod 16).
    assign w_unused_bits = {w_ab_carry[c_SUM_W], w_full_carry[c_SUM_W],
                            w_full_sum[c_SUM_W-1:4]};

    assign w_sum_e3 = w_full_sum[3:0];

    // Overflow compares operand signs with the excess-3 result, so the
    // offset itself can push a same-sign pair into overflow (2+3+3 = 8).
    assign w_overflow = (bus.A[3] == bus.B[3]) && (w_sum_e3[3] != bus.A[3]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_q      <= 4'd0;
            r_overflow_q <= 1'b0;
        end else begin
            r_sum_q      <= w_sum_e3;
            r_overflow_q <= w_overflow;
        end
    end

`ifdef ADDER4_STICKY_OVF_EN
    logic r_ovf_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_overflow) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign bus.ovf_sticky = r_ovf_sticky;
`else
    assign bus.ovf_sticky = 1'b0;
`endif

    assign bus.sum_e3     = w_sum_e3;
    assign bus.overflow   = w_overflow;
    assign bus.sum_q      = r_sum_q;
    assign bus.overflow_q = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_adder4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_adder4
//  Description : Scoreboard bench for adder4. The stimulus process drives
//                A/B on the falling edge and queues the expected result from
//                an arithmetic reference model; a monitor process pops one
//                entry after each rising edge and compares both the
//                combinational and registered outputs plus the sticky flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder4;

    localparam int c_HALF_PERIOD = 5;

`ifdef ADDER4_STICKY_OVF_EN
    localparam bit c_STICKY_EN = 1'b1;
`else
    localparam bit c_STICKY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] sum;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    exp_t exp_q[$];
    bit   model_sticky = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    adder4_if bus_if ();

    adder4 #(.OFFSET(4'd3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #c_HALF_PERIOD clk = ~clk;

    // Reference: plain integer arithmetic, signs read as "value >= 8".
    function automatic exp_t model(int a, int b);
        exp_t e;
        int   s;
        bit   sa, sb, ss;
        s  = (a + b + 3) % 16;
        sa = (a >= 8);
        sb = (b >= 8);
        ss = (s >= 8);
        e.sum = s[3:0];
        e.ovf = (sa == sb) && (ss != sa);
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (A=%0d B=%0d t=%0t)",
                     nm, act, exp_v, bus_if.A, bus_if.B, $time);
        end
    endtask

    task automatic apply(input int a, input int b);
        @(negedge clk);
        bus_if.A = a[3:0];
        bus_if.B = b[3:0];
        exp_q.push_back(model(a, b));
    endtask

    // Let the monitor consume the last queued entry.
    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (rst) begin
                model_sticky = 1'b0;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sum_e3",     int'(bus_if.sum_e3),     int'(e.sum));
                chk("overflow",   int'(bus_if.overflow),   int'(e.ovf));
                chk("sum_q",      int'(bus_if.sum_q),      int'(e.sum));
                chk("overflow_q", int'(bus_if.overflow_q), int'(e.ovf));
                if (c_STICKY_EN && e.ovf) model_sticky = 1'b1;
                chk("ovf_sticky", int'(bus_if.ovf_sticky), int'(model_sticky));
            end
        end
    end

    // Registered outputs must be zero while rst is high; combinational ones keep tracking.
    task automatic check_in_reset(input string tag);
        exp_t e;
        e = model(int'(bus_if.A), int'(bus_if.B));
        chk({tag, "_sum_q"},      int'(bus_if.sum_q),      0);
        chk({tag, "_overflow_q"}, int'(bus_if.overflow_q), 0);
        chk({tag, "_ovf_sticky"}, int'(bus_if.ovf_sticky), 0);
        chk({tag, "_comb_sum"},   int'(bus_if.sum_e3),     int'(e.sum));
        chk({tag, "_comb_ovf"},   int'(bus_if.overflow),   int'(e.ovf));
    endtask

    initial begin
        bus_if.A = 4'd0;
        bus_if.B = 4'd0;
        #1 rst = 1'b1;
        #2 check_in_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, including the wrap and differing-sign cases
        apply(0, 0);
        apply(1, 1);
        apply(4, 0);
        apply(2, 3);
        apply(4, 1);
        apply(5, 5);
        apply(15, 15);
        apply(8, 8);
        apply(12, 4);
        drain();

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                apply(a, b);
            end
        end
        drain();

        // Random operands
        for (int i = 0; i < 100; i++) begin
            apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        drain();

        // Mid-run reset with nonzero registered state
        apply(5, 5);
        drain();
        rst = 1'b1;
        #1 check_in_reset("midrst");
        @(negedge clk);
        rst = 1'b0;

        // Sticky: one overflowing cycle, then benign operands
        apply(2, 3);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0);
        end
        drain();
        rst = 1'b1;
        #1 check_in_reset("stickyrst");
        @(negedge clk);
        rst = 1'b0;
        apply(1, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
